// File: rtl/axi_lite_xbar_router.sv
// axi_lite_xbar_router
//   Single-master to NUM_SLAVES AXI4-Lite router. Presents the pending request
//   address to an external combinational decoder, latches the returned
//   one-hot route, and forwards exactly one transaction at a time to the
//   selected slave. The slave's response is returned to the master.
//   Addresses that the decoder flags as unmapped are answered locally with
//   DECERR.
//
// Ports
//   clock, reset         : system clock, synchronous active-high reset
//   dec_addr             : address presented to the decoder
//   dec_sel, dec_err     : one-hot slave select and no-match flag from the decoder
//   m_ar*, m_r*          : master read address and read data channels
//   m_aw*, m_w*, m_b*    : master write address, write data and write response channels
//   s_ar*, s_r*          : per-slave read channels; slave i owns slice i of each packed bus
//   s_aw*, s_w*, s_b*    : per-slave write channels; address, data and strobe are broadcast
module axi_lite_xbar_router #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [ADDR_WIDTH-1:0]          dec_addr,
  input  logic [NUM_SLAVES-1:0]          dec_sel,
  input  logic                           dec_err,
  input  logic                           m_arvalid,
  output logic                           m_arready,
  input  logic [ADDR_WIDTH-1:0]          m_araddr,
  output logic                           m_rvalid,
  input  logic                           m_rready,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [1:0]                     m_rresp,
  input  logic                           m_awvalid,
  output logic                           m_awready,
  input  logic [ADDR_WIDTH-1:0]          m_awaddr,
  input  logic                           m_wvalid,
  output logic                           m_wready,
  input  logic [DATA_WIDTH-1:0]          m_wdata,
  input  logic [DATA_WIDTH/8-1:0]        m_wstrb,
  output logic                           m_bvalid,
  input  logic                           m_bready,
  output logic [1:0]                     m_bresp,
  output logic [NUM_SLAVES-1:0]          s_arvalid,
  input  logic [NUM_SLAVES-1:0]          s_arready,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic [NUM_SLAVES-1:0]          s_rvalid,
  output logic [NUM_SLAVES-1:0]          s_rready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES*2-1:0]        s_rresp,
  output logic [NUM_SLAVES-1:0]          s_awvalid,
  input  logic [NUM_SLAVES-1:0]          s_awready,
  output logic [ADDR_WIDTH-1:0]          s_awaddr,
  output logic [NUM_SLAVES-1:0]          s_wvalid,
  input  logic [NUM_SLAVES-1:0]          s_wready,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic [NUM_SLAVES-1:0]          s_bvalid,
  output logic [NUM_SLAVES-1:0]          s_bready,
  input  logic [NUM_SLAVES*2-1:0]        s_bresp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_RESP, RD_ERR, WR_REQ, WR_RESP, WR_ERR
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    err_q;
  logic                    aw_done;
  logic                    w_done;

  // Handshake inputs and response payload of the latched slave.
  logic                    sel_arready;
  logic                    sel_rvalid;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [1:0]              sel_rresp;
  logic                    sel_awready;
  logic                    sel_wready;
  logic                    sel_bvalid;
  logic [1:0]              sel_bresp;
  logic                    aw_fire;
  logic                    w_fire;

  always_comb begin
    sel_arready = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    sel_rresp   = '0;
    sel_awready = 1'b0;
    sel_wready  = 1'b0;
    sel_bvalid  = 1'b0;
    sel_bresp   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_arready = s_arready[i];
        sel_rvalid  = s_rvalid[i];
        sel_rdata   = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rresp   = s_rresp[i*2 +: 2];
        sel_awready = s_awready[i];
        sel_wready  = s_wready[i];
        sel_bvalid  = s_bvalid[i];
        sel_bresp   = s_bresp[i*2 +: 2];
      end
    end
  end

  assign aw_fire = (state == WR_REQ) && !aw_done && sel_awready;
  assign w_fire  = (state == WR_REQ) && !w_done  && sel_wready;

  // While idle the decoder sees the request about to be accepted (read wins).
  assign dec_addr = (state == IDLE) ? (m_arvalid ? m_araddr : m_awaddr) : addr_q;
  assign s_araddr = addr_q;
  assign s_awaddr = addr_q;
  assign s_wdata  = wdata_q;
  assign s_wstrb  = wstrb_q;

  always_comb begin
    m_arready = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_bvalid  = 1'b0;
    m_bresp   = '0;
    s_arvalid = '0;
    s_rready  = '0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    case (state)
      IDLE: begin
        // Readies are held low while reset is asserted so no handshake is
        // visible to the master for a request the router will discard.
        if (!reset) begin
          m_arready = m_arvalid;
          m_awready = !m_arvalid && m_awvalid && m_wvalid;
          m_wready  = !m_arvalid && m_awvalid && m_wvalid;
        end
      end
      RD_REQ:  s_arvalid = sel_q;
      RD_RESP: begin
        m_rvalid = sel_rvalid;
        if (sel_rvalid) begin
          m_rdata = sel_rdata;
          m_rresp = sel_rresp;
        end
        s_rready = m_rready ? sel_q : '0;
      end
      // err_q is only set on the way into the error states, so it forms the
      // DECERR code directly.
      RD_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = {2{err_q}};
      end
      WR_REQ: begin
        s_awvalid = aw_done ? '0 : sel_q;
        s_wvalid  = w_done  ? '0 : sel_q;
      end
      WR_RESP: begin
        m_bvalid = sel_bvalid;
        if (sel_bvalid) m_bresp = sel_bresp;
        s_bready = m_bready ? sel_q : '0;
      end
      WR_ERR: begin
        m_bvalid = 1'b1;
        m_bresp  = {2{err_q}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m_arvalid) begin
            addr_q <= m_araddr;
            sel_q  <= dec_sel;
            err_q  <= dec_err;
            state  <= dec_err ? RD_ERR : RD_REQ;
          end else if (m_awvalid && m_wvalid) begin
            addr_q  <= m_awaddr;
            wdata_q <= m_wdata;
            wstrb_q <= m_wstrb;
            sel_q   <= dec_sel;
            err_q   <= dec_err;
            state   <= dec_err ? WR_ERR : WR_REQ;
          end
        end
        RD_REQ:  if (sel_arready) state <= RD_RESP;
        RD_RESP: if (sel_rvalid && m_rready) state <= IDLE;
        RD_ERR:  if (m_rready) state <= IDLE;
        WR_REQ: begin
          // Sticky per-channel completion; both may finish in the same cycle.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            aw_done <= aw_done || aw_fire;
            w_done  <= w_done || w_fire;
          end
        end
        WR_RESP: if (sel_bvalid && m_bready) state <= IDLE;
        WR_ERR:  if (m_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_xbar_router.sv
// Testbench for axi_lite_xbar_router: two behavioural slaves, a behavioural
// address decoder, and a response scoreboard fed at stimulus time.
module tb_axi_lite_xbar_router;

  logic        clk;
  logic        rst;
  logic [31:0] dec_addr;
  logic [1:0]  dec_sel;
  logic        dec_err;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic [1:0]  s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [1:0]  s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [1:0]  s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bvalid, s_bready;
  logic [3:0]  s_bresp;

  axi_lite_xbar_router #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(2)) dut (
    .clock(clk), .reset(rst),
    .dec_addr(dec_addr), .dec_sel(dec_sel), .dec_err(dec_err),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Address map: 0x8xxxxxxx -> slave 1, 0xAxxxxxxx -> slave 0, else unmapped.
  always_comb begin
    dec_sel = 2'b00;
    dec_err = 1'b0;
    case (dec_addr[31:28])
      4'h8:    dec_sel = 2'b10;
      4'hA:    dec_sel = 2'b01;
      default: dec_err = 1'b1;
    endcase
  end

  // Slave models: AR accepted immediately, read data one cycle later;
  // AW/W ready after aw_wait/w_wait cycles of valid; B one cycle after both.
  logic [31:0] rd_val [2];
  int          aw_wait, w_wait;
  int          cnt_aw [2];
  int          cnt_w  [2];
  bit          got_aw [2];
  bit          got_w  [2];

  always_comb begin
    s_arready = 2'b00;
    s_awready = 2'b00;
    s_wready  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      s_arready[i] = s_arvalid[i];
      s_awready[i] = s_awvalid[i] && (cnt_aw[i] >= aw_wait);
      s_wready[i]  = s_wvalid[i]  && (cnt_w[i]  >= w_wait);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      s_rvalid <= 2'b00;
      s_bvalid <= 2'b00;
      s_rdata  <= '0;
      s_rresp  <= '0;
      s_bresp  <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_aw[i] <= 0;
        cnt_w[i]  <= 0;
        got_aw[i] <= 1'b0;
        got_w[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s_arvalid[i] && s_arready[i]) begin
          s_rvalid[i]         <= 1'b1;
          s_rdata[i*32 +: 32] <= rd_val[i];
          s_rresp[i*2 +: 2]   <= 2'b00;
        end else if (s_rvalid[i] && s_rready[i]) begin
          s_rvalid[i] <= 1'b0;
        end
        if (s_awvalid[i]) begin
          if (s_awready[i]) begin
            cnt_aw[i] <= 0;
            got_aw[i] <= 1'b1;
          end else cnt_aw[i] <= cnt_aw[i] + 1;
        end
        if (s_wvalid[i]) begin
          if (s_wready[i]) begin
            cnt_w[i] <= 0;
            got_w[i] <= 1'b1;
          end else cnt_w[i] <= cnt_w[i] + 1;
        end
        if (got_aw[i] && got_w[i]) begin
          s_bvalid[i]       <= 1'b1;
          s_bresp[i*2 +: 2] <= 2'b00;
          got_aw[i]         <= 1'b0;
          got_w[i]          <= 1'b0;
        end else if (s_bvalid[i] && s_bready[i]) begin
          s_bvalid[i] <= 1'b0;
        end
      end
    end
  end

  // Activity monitors: cycles each valid/ready was high at a clock edge.
  int arv_cnt [2];
  int awv_cnt [2];
  int wv_cnt  [2];
  int arr_cnt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      arv_cnt[i] = 0;
      awv_cnt[i] = 0;
      wv_cnt[i]  = 0;
    end
    arr_cnt = 0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (s_arvalid[i]) arv_cnt[i] <= arv_cnt[i] + 1;
      if (s_awvalid[i]) awv_cnt[i] <= awv_cnt[i] + 1;
      if (s_wvalid[i])  wv_cnt[i]  <= wv_cnt[i] + 1;
    end
    if (m_arready) arr_cnt <= arr_cnt + 1;
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb [$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit out_sig(input int which);
    case (which)
      0:       return m_arready;
      1:       return m_rvalid;
      2:       return m_awready;
      default: return m_bvalid;
    endcase
  endfunction

  // Entered just after a falling edge; returns with the signal high, still
  // before the next rising edge, or ok=0 after the cycle budget.
  task automatic wait_out(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (out_sig(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_read(input logic [31:0] a, input bit mapped);
    bit ok;
    m_arvalid = 1'b1;
    m_araddr  = a;
    wait_out(0, ok);
    check("ar_accept", ok, 1);
    @(negedge clk);
    m_arvalid = 1'b0;
    if (mapped) begin
      #1;
      check("rdata_gated", m_rdata, 0);
      check("s_araddr", s_araddr, a);
    end
  endtask

  task automatic collect_r();
    bit   ok;
    exp_t e;
    e = '{data: 32'h0, resp: 2'b00};
    m_rready = 1'b1;
    wait_out(1, ok);
    check("r_timeout", ok, 1);
    check("sb_nonempty_r", sb.size() > 0, 1);
    if (sb.size() > 0) e = sb.pop_front();
    check("rdata", m_rdata, e.data);
    check("rresp", m_rresp, e.resp);
    @(negedge clk);
  endtask

  task automatic accept_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    m_awvalid = 1'b1;
    m_wvalid  = 1'b1;
    m_awaddr  = a;
    m_wdata   = d;
    m_wstrb   = s;
    wait_out(2, ok);
    check("aw_accept", ok, 1);
    check("w_accept", m_wready, 1);
    @(negedge clk);
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
  endtask

  task automatic collect_b(input int hold);
    bit   ok;
    exp_t e;
    e = '{data: 32'h0, resp: 2'b00};
    m_bready = (hold == 0);
    wait_out(3, ok);
    check("b_timeout", ok, 1);
    check("sb_nonempty_b", sb.size() > 0, 1);
    if (sb.size() > 0) e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      check("b_hold_valid", m_bvalid, 1);
      check("b_hold_resp", m_bresp, e.resp);
      @(negedge clk);
      #1;
    end
    m_bready = 1'b1;
    #1;
    check("bresp", m_bresp, e.resp);
    @(negedge clk);
    #1;
    check("b_done_idle", m_bvalid, 0);
  endtask

  int a0, a1, ar, aw0, aw1, w0, w1;

  initial begin
    rst = 1'b1;
    m_arvalid = 1'b0; m_araddr = '0; m_rready = 1'b1;
    m_awvalid = 1'b0; m_awaddr = '0; m_wvalid = 1'b0; m_wdata = '0; m_wstrb = '0;
    m_bready = 1'b1;
    aw_wait = 0; w_wait = 0;
    rd_val[0] = '0; rd_val[1] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", m_arready, 0);
    check("rst_rvalid", m_rvalid, 0);
    check("rst_bvalid", m_bvalid, 0);
    check("rst_rdata", m_rdata, 0);
    check("rst_resp", {m_rresp, m_bresp}, 0);
    check("rst_s_valid", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
    check("rst_s_addr", s_araddr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Read to slave 1
    rd_val[1] = 32'hDEADBEEF;
    a0 = arv_cnt[0]; a1 = arv_cnt[1]; ar = arr_cnt;
    sb.push_back('{data: 32'hDEADBEEF, resp: 2'b00});
    accept_read(32'h80000010, 1'b1);
    collect_r();
    check("rd1_s0_arvalid", arv_cnt[0] - a0, 0);
    check("rd1_s1_arvalid", arv_cnt[1] - a1, 1);
    check("rd1_arready_cycles", arr_cnt - ar, 1);

    // Write to slave 0, AW ready two cycles before W ready
    aw_wait = 0; w_wait = 2;
    sb.push_back('{data: 32'h0, resp: 2'b00});
    accept_write(32'ha00003f8, 32'h41, 4'h1);
    #1;
    check("wr_c0_awvalid", s_awvalid, 2'b01);
    check("wr_c0_wvalid", s_wvalid, 2'b01);
    check("wr_awaddr", s_awaddr, 32'ha00003f8);
    check("wr_wdata", s_wdata, 32'h41);
    check("wr_wstrb", s_wstrb, 4'h1);
    @(negedge clk); #1;
    check("wr_c1_awvalid", s_awvalid, 2'b00);
    check("wr_c1_wvalid", s_wvalid, 2'b01);
    @(negedge clk); #1;
    check("wr_c2_wvalid", s_wvalid, 2'b01);
    @(negedge clk);
    collect_b(0);
    w_wait = 0;

    // Unmapped read
    a0 = arv_cnt[0]; a1 = arv_cnt[1];
    aw0 = awv_cnt[0]; aw1 = awv_cnt[1]; w0 = wv_cnt[0]; w1 = wv_cnt[1];
    sb.push_back('{data: 32'h0, resp: 2'b11});
    accept_read(32'h00001000, 1'b0);
    collect_r();
    check("rderr_s_valids", (arv_cnt[0] - a0) + (arv_cnt[1] - a1), 0);

    // Unmapped write with master B ready held low for 3 cycles
    sb.push_back('{data: 32'h0, resp: 2'b11});
    accept_write(32'h20000000, 32'h55, 4'hf);
    collect_b(3);
    check("wrerr_s_valids", (awv_cnt[0] - aw0) + (awv_cnt[1] - aw1) + (wv_cnt[0] - w0) + (wv_cnt[1] - w1), 0);

    // Simultaneous read and write: read first, write right after
    rd_val[0] = 32'h12345678;
    sb.push_back('{data: 32'h12345678, resp: 2'b00});
    sb.push_back('{data: 32'h0, resp: 2'b00});
    m_arvalid = 1'b1; m_araddr = 32'ha0000000;
    m_awvalid = 1'b1; m_wvalid = 1'b1;
    m_awaddr = 32'h80000004; m_wdata = 32'h99; m_wstrb = 4'hf;
    #1;
    check("arb_arready", m_arready, 1);
    check("arb_awready", m_awready, 0);
    @(negedge clk);
    m_arvalid = 1'b0;
    #1;
    check("arb_aw_blocked", m_awready, 0);
    collect_r();
    #1;
    check("wr_after_rd_aw", m_awready, 1);
    check("wr_after_rd_w", m_wready, 1);
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    #1;
    check("arb_wr_slave1", s_awvalid, 2'b10);
    collect_b(0);

    // Reset during RD_RESP with slave data pending
    rd_val[1] = 32'hCAFEF00D;
    m_rready = 1'b0;
    accept_read(32'h80000020, 1'b1);
    begin
      bit ok;
      wait_out(1, ok);
      check("pend_rvalid", ok, 1);
    end
    rst = 1'b1;
    m_awaddr = 32'h00000abc;
    @(negedge clk); #1;
    check("midrst_rvalid", m_rvalid, 0);
    check("midrst_rdata", m_rdata, 0);
    check("midrst_s_rready", s_rready, 0);
    check("midrst_idle", dec_addr, 32'h00000abc);
    rst = 1'b0;
    m_rready = 1'b1;
    m_awaddr = '0;
    @(negedge clk);
    rd_val[1] = 32'h0BADF00D;
    sb.push_back('{data: 32'h0BADF00D, resp: 2'b00});
    accept_read(32'h80000030, 1'b1);
    collect_r();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_xbar_router.md
Name: axi_lite_xbar_router

Overview:
- Single-master to NUM_SLAVES AXI4-Lite router in the NPC memory path. Sits directly downstream of the combinational address decoder.
- Presents the pending request address to the decoder and consumes its one-hot select and error flag.
- Latches the route, forwards one transaction at a time to the selected slave, and returns that slave's response to the master.
- Unmapped addresses are answered locally with DECERR.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- NUM_SLAVES, 2, number of downstream slaves

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- dec_addr  out  ADDR_WIDTH  address presented to the decoder (combinational)
- dec_sel  in  NUM_SLAVES  one-hot slave select from the decoder
- dec_err  in  1  no slave matched
- m_arvalid/m_arready  in/out  1  master read address handshake; m_araddr  in  ADDR_WIDTH
- m_rvalid/m_rready  out/in  1  master read data handshake; m_rdata  out  DATA_WIDTH; m_rresp  out  2
- m_awvalid/m_awready  in/out  1  master write address handshake; m_awaddr  in  ADDR_WIDTH
- m_wvalid/m_wready  in/out  1  master write data handshake; m_wdata  in  DATA_WIDTH; m_wstrb  in  DATA_WIDTH/8
- m_bvalid/m_bready  out/in  1  master write response handshake; m_bresp  out  2
- s_arvalid  out  NUM_SLAVES; s_arready  in  NUM_SLAVES; s_araddr  out  ADDR_WIDTH (broadcast)
- s_rvalid  in  NUM_SLAVES; s_rready  out  NUM_SLAVES; s_rdata  in  NUM_SLAVES*DATA_WIDTH; s_rresp  in  NUM_SLAVES*2
- s_awvalid  out  NUM_SLAVES; s_awready  in  NUM_SLAVES; s_awaddr  out  ADDR_WIDTH (broadcast)
- s_wvalid  out  NUM_SLAVES; s_wready  in  NUM_SLAVES; s_wdata  out  DATA_WIDTH; s_wstrb  out  DATA_WIDTH/8
- s_bvalid  in  NUM_SLAVES; s_bready  out  NUM_SLAVES; s_bresp  in  NUM_SLAVES*2
- Slave i owns bits [i*W +: W] of each packed bus.

Behaviour:
- Clock is `clock`, reset is `reset`. One clock domain; reset is synchronous and active-high.
- Reset: state=IDLE. All valid/ready outputs 0. Latched addr, data, strb, sel, and err cleared to 0. m_rdata=0, m_rresp=0, m_bresp=0.
- Reset mid-transaction abandons it: state returns to IDLE the next cycle, with no response to the master.
- States: IDLE, RD_REQ, RD_RESP, RD_ERR, WR_REQ, WR_RESP, WR_ERR.
- dec_addr in IDLE: m_araddr if m_arvalid, else m_awaddr. In all other states: the latched addr_q.
- IDLE arbitration:
  - Read has fixed priority over write.
  - If m_arvalid: m_arready=1 (combinational) and the request is accepted that cycle. Latch addr_q, sel_q=dec_sel, err_q=dec_err. Next state: RD_ERR if dec_err, else RD_REQ.
  - Else if m_awvalid && m_wvalid: m_awready=m_wready=1 in the same cycle. Latch addr, wdata, wstrb, sel, err. Next state: WR_ERR if dec_err, else WR_REQ.
  - A lone m_awvalid or lone m_wvalid is not accepted.
- RD_REQ:
  - s_arvalid = sel_q; s_araddr = addr_q. Hold until s_arready[sel] is high, then go to RD_RESP.
  - Min latency: accept to slave AR is 1 cycle.
- RD_RESP:
  - Pass through combinationally: m_rvalid=s_rvalid[sel], m_rdata/m_rresp from slave sel, s_rready[sel]=m_rready.
  - On m_rvalid && m_rready, go to IDLE.
  - m_rdata/m_rresp are muxed only while m_rvalid=1; otherwise they are 0.
- RD_ERR: m_rvalid=1, m_rdata=0, m_rresp=2'b11. On m_rready, go to IDLE. No slave signal is touched.
- WR_REQ:
  - s_awvalid[sel] = !aw_done; s_wvalid[sel] = !w_done. aw_done and w_done are sticky flags set by their handshakes.
  - AW and W may complete in the same or different cycles. Each valid drops the cycle after its own handshake.
  - When both are done (including simultaneous completion), clear both flags and go to WR_RESP.
- WR_RESP:
  - Pass through: m_bvalid=s_bvalid[sel], m_bresp from slave sel, s_bready[sel]=m_bready.
  - On handshake, go to IDLE.
- WR_ERR: m_bvalid=1, m_bresp=2'b11. On m_bready, go to IDLE.
- Outstanding transactions: exactly one. Master ready outputs are 0 in every state except IDLE.
- Unselected slaves see valid=0 and ready=0 at all times.
- If dec_sel is not one-hot, behaviour is undefined. The decoder guarantees one-hot or all-zero with err=1.
- Back-to-back: the earliest the next request can be accepted is the cycle after return to IDLE.
- Minimum read turnaround with zero-wait slaves: 3 cycles (accept, slave AR, response).

Test Plan:
- Read to slave 1: araddr=0x80000010; slave returns rdata=0xDEADBEEF, rresp=0 one cycle after AR -> m_rdata=0xDEADBEEF, m_rresp=0; only s_arvalid[1] is ever high; m_arready is high for exactly 1 cycle.
- Write to slave 0: awaddr=0xa00003f8, wdata=0x41, wstrb=0x1; slave asserts awready 2 cycles before wready -> s_awvalid drops after its handshake while s_wvalid holds; m_bresp=0 is returned after s_bvalid.
- Unmapped read at 0x00001000 (dec_err=1) -> RD_ERR; m_rvalid=1, m_rresp=2'b11, m_rdata=0; all s_* valids stay 0.
- Unmapped write, with m_bready held low for 3 cycles -> m_bvalid=1 and m_bresp=2'b11 stay stable until m_bready rises, then return to IDLE.
- Simultaneous m_arvalid and m_awvalid+m_wvalid in IDLE -> read is served first; write is accepted the cycle after the read completes.
- Assert reset during RD_RESP, with slave rvalid pending -> next cycle IDLE, all outputs at reset values; a new read is then accepted normally.
